// File: rtl/instr_enc_pkg.sv
// Shared constants, FSM encoding and the micro-op to MIPS word encoder for instr_encoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD       = 4'd0,
    OP_SUB       = 4'd1,
    OP_AND       = 4'd2,
    OP_OR        = 4'd3,
    OP_SLT       = 4'd4,
    OP_LW        = 4'd5,
    OP_SW        = 4'd6,
    OP_BEQ       = 4'd7,
    OP_ADDI      = 4'd8,
    OP_JAL       = 4'd9,
    OP_JR        = 4'd10,
    OP_ADDU_QB   = 4'd11,
    OP_ADDU_S_QB = 4'd12
  } op_e;

  localparam logic [5:0] OPC_RTYPE    = 6'b000000;
  localparam logic [5:0] OPC_LW       = 6'b100011;
  localparam logic [5:0] OPC_SW       = 6'b101011;
  localparam logic [5:0] OPC_BEQ      = 6'b000100;
  localparam logic [5:0] OPC_ADDI     = 6'b001000;
  localparam logic [5:0] OPC_JAL      = 6'b000011;
  localparam logic [5:0] OPC_JR       = 6'b000111;
  localparam logic [5:0] OPC_SPECIAL3 = 6'b011111;

  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_ADDU_QB = 6'b010000;

  localparam logic [4:0] SHAMT_ADDU_S_QB = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_ADDU_S_QB);
  endfunction

  function automatic logic [31:0] enc_word(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADD:       w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:       w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:       w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:        w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      OP_SLT:       w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      OP_LW:        w = {OPC_LW, rs, rt, imm};
      OP_SW:        w = {OPC_SW, rs, rt, imm};
      OP_BEQ:       w = {OPC_BEQ, rs, rt, imm};
      OP_ADDI:      w = {OPC_ADDI, rs, rt, imm};
      OP_JAL:       w = {OPC_JAL, target};
      OP_JR:        w = {OPC_JR, rs, 21'd0};
      OP_ADDU_QB:   w = {OPC_SPECIAL3, rs, rt, rd, 5'd0, FN_ADDU_QB};
      OP_ADDU_S_QB: w = {OPC_SPECIAL3, rs, rt, rd, SHAMT_ADDU_S_QB, FN_ADDU_QB};
      default:      w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous FIFO of {addr, instr}; the head output keeps the last popped word while empty.
module instr_enc_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 42,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? r_hold : r_mem[r_rd_ptr];

  // Storage is not reset: an entry is only ever observed after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes micro-ops into MIPS words, buffers them with word addresses, frames bursts.
// Optional ENC_ILLEGAL_NOP_EN: illegal ops emit a NOP and advance the address.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DW    = ADDR_W + 32;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;

  logic              w_hs;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_enc;
  logic [31:0]       w_word;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_count;
  logic [DW-1:0]     w_head;
  logic              w_start_ok;

  assign w_enc      = enc_word(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  assign w_legal    = op_legal(in_op);
  assign in_ready   = (r_state == ST_RUN) && !w_full;
  assign w_hs       = in_valid && in_ready;
  assign w_pop      = !w_empty && out_ready;
  assign w_start_ok = (r_state == ST_IDLE) && start;

`ifdef ENC_ILLEGAL_NOP_EN
  assign w_push = w_hs;
  assign w_word = w_legal ? w_enc : 32'h0000_0000;
`else
  assign w_push = w_hs && w_legal;
  assign w_word = w_enc;
`endif

  instr_enc_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_addr, w_word}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign out_addr  = w_head[DW-1:32];
  assign out_instr = w_head[31:0];
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // DRAIN exits when the FIFO is empty now or the pending pop takes the final entry.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_hs && in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_empty || (w_pop && (w_count == (PTR_W+1)'(1)))) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_ok)  r_addr <= base_addr;
      else if (w_push) r_addr <= r_addr + ADDR_W'(1);
      if (w_start_ok)              r_err <= 1'b0;
      else if (w_hs && !w_legal)   r_err <= 1'b1;
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encodes abstract micro-op requests into 32-bit MIPS instruction words that the processor's main decoder and ALU-op decoder accept. A host-side program loader or self-test generator feeds this block. The encoded words are buffered in a small FIFO and emitted with an incrementing instruction-memory word address. A start/last/done FSM frames each program burst.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2
ADDR_W, 10, width of instruction-memory word address

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a burst, loads address from base_addr
base_addr  in  ADDR_W  first word address of the burst
in_valid  in  1  micro-op valid
in_ready  out  1  micro-op accepted when in_valid && in_ready
in_last  in  1  marks the final micro-op of the burst
in_op  in  4  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 JAL, 10 JR, 11 ADDU_QB, 12 ADDU_S_QB; 13-15 illegal
in_rs, in_rt, in_rd  in  5 each  register fields
in_imm  in  16  immediate for LW/SW/BEQ/ADDI
in_target  in  26  jump target for JAL
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the word
out_instr  out  32  encoded word at FIFO head
out_addr  out  ADDR_W  word address paired with out_instr
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of burst
err  out  1  sticky: illegal op seen since last start

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err=0. FSM resets to IDLE, FIFO empty, address counter 0.
- Encoding (combinational, registered into the FIFO):
  - R-type ops (0-4): opcode 000000, rs/rt/rd, shamt 0. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type ops (5-8): {opcode, rs, rt, imm}. Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - JAL: {000011, target}.
  - JR: {000111, rs, 21'b0}.
  - ADDU_QB: {011111, rs, rt, rd, 5'b00000, 010000}.
  - ADDU_S_QB: same as ADDU_QB with shamt 5'b01000.
- FSM states and transitions:
  - IDLE: start -> RUN; address counter <= base_addr; err <= 0. start in any other state is ignored.
  - RUN: in_ready = !fifo_full. Handshake with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. When the FIFO becomes empty (last pop completes) -> IDLE, and done pulses that same cycle.
- Latency: a micro-op accepted at edge N appears at the FIFO head with out_valid=1 after edge N if the FIFO was empty. There is no combinational in->out path.
- out_addr: the address is captured into the FIFO with each word. The counter increments once per accepted legal op and wraps modulo 2^ADDR_W.
- Full FIFO: in_ready=0 even if a pop occurs the same cycle. The FIFO is never written when full.
- Empty FIFO: out_valid=0. out_instr holds its last value.
- Simultaneous push and pop (not full, not empty): both occur; occupancy is unchanged.
- Illegal op (13-15): accepted (handshake completes), err set. No word is pushed and the address does not advance. in_last on an illegal op still moves the FSM to DRAIN.
- Burst with in_last on an empty FIFO cycle: DRAIN -> IDLE once the FIFO empties; done is always exactly one pulse per burst.
- rst_n asserted mid-burst: immediate return to reset values, and FIFO contents are discarded.

Optional Feature:
ENC_ILLEGAL_NOP_EN
- Defined: an illegal op pushes 32'h00000000 (a NOP) and advances the address, so program layout is preserved. err is still set.
- Undefined: illegal ops are dropped as described in Behaviour.

Decomposition:
- Shared package instr_enc_pkg holds:
  - op enum constants OP_ADD..OP_ADDU_S_QB;
  - 6-bit opcode constants (OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_JAL, OPC_JR, OPC_SPECIAL3);
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_ADDU_QB);
  - SHAMT_ADDU_S_QB = 5'b01000;
  - FSM state encoding.
- One sub-module, instr_enc_fifo: synchronous FIFO of {addr, instr}, with parameters FIFO_DEPTH and width.

Test Plan:
- start with base_addr=0x010; ADD rs=1 rt=2 rd=3 (in_last) -> out_instr=0x00221820, out_addr=0x010, done pulses when popped, busy falls.
- Burst LW rs=4 rt=5 imm=0x0008, BEQ rs=1 rt=2 imm=0xFFFF, JAL target=0x0000100 -> 0x8C850008, 0x1022FFFF, 0x0C000100 at consecutive addresses.
- ADDU_QB rs=1 rt=2 rd=3 -> 0x7C221810; ADDU_S_QB -> 0x7C221A10; JR rs=31 -> 0x1FE00000.
- Hold out_ready=0 and push FIFO_DEPTH+2 ops -> in_ready falls after FIFO_DEPTH accepts; release -> all words in order, none lost or duplicated.
- base_addr=2^ADDR_W-1 with two ops -> out_addr wraps to 0; illegal op 14 mid-burst -> err=1, no word emitted (NOP emitted with ENC_ILLEGAL_NOP_EN).
- rst_n low with 3 words queued during RUN -> out_valid=0, busy=0 on the next cycle; no done pulse.
